// File: rtl/bsg_clk_gen_monitor_counter.sv
// bsg_clk_gen_monitor_counter: counts synchronized rising edges of an async monitor clock
// over a programmable window of reference cycles and returns the count via valid/yumi.
module bsg_clk_gen_monitor_counter #(
    parameter int window_width_p = 16,
    parameter int count_width_p  = 16,
    parameter int sync_stages_p  = 2
) (
    input  logic                      clk_i,
    input  logic                      reset_i,
    input  logic                      clk_monitor_i,
    input  logic                      start_i,
    input  logic [window_width_p-1:0] window_i,
    output logic                      busy_o,
    output logic                      v_o,
    output logic [count_width_p-1:0]  count_o,
    output logic                      overflow_o,
    input  logic                      yumi_i
);
    typedef enum logic [1:0] {IDLE, MEASURE, DONE} state_e;
    state_e                    state_q, state_d;
    logic [sync_stages_p-1:0]  sync_q;
    logic                      prev_q;
    logic                      rise;
    logic [window_width_p-1:0] win_q, win_d;
    logic [count_width_p-1:0]  count_q, count_d;
    logic                      ovf_q, ovf_d;

    assign rise = sync_q[sync_stages_p-1] & ~prev_q;

    always_ff @(posedge clk_i) begin
        if (reset_i) begin
            state_q <= IDLE;
            sync_q  <= '0;
            prev_q  <= 1'b0;
            win_q   <= '0;
            count_q <= '0;
            ovf_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sync_q  <= {sync_q[sync_stages_p-2:0], clk_monitor_i};
            prev_q  <= sync_q[sync_stages_p-1];
            win_q   <= win_d;
            count_q <= count_d;
            ovf_q   <= ovf_d;
        end
    end

    always_comb begin
        state_d = state_q;
        win_d   = win_q;
        count_d = count_q;
        ovf_d   = ovf_q;
        case (state_q)
            IDLE: if (start_i && window_i != '0) begin
                state_d = MEASURE;
                win_d   = window_i;
                count_d = '0;
                ovf_d   = 1'b0;
            end
            MEASURE: begin
                win_d = win_q - 1'b1;
                // saturate at all-ones; overflow stays set until the next start
                if (rise) begin
                    count_d = &count_q ? count_q : count_q + 1'b1;
                    ovf_d   = ovf_q | (&count_q);
                end
                state_d = (win_q == window_width_p'(1)) ? DONE : MEASURE;
            end
            DONE: state_d = yumi_i ? IDLE : DONE;
            default: state_d = IDLE;
        endcase
    end

    assign busy_o     = state_q != IDLE;
    assign v_o        = state_q == DONE;
    assign count_o    = count_q;
    assign overflow_o = ovf_q;
endmodule

// File: tb/tb_bsg_clk_gen_monitor_counter.sv
// tb_bsg_clk_gen_monitor_counter: table-driven and randomized checks of the edge counter,
// using two instances (16-bit/2-stage and 4-bit/3-stage) driven in lockstep.
module tb_bsg_clk_gen_monitor_counter;
    logic        clk = 1'b0;
    logic        reset = 1'b1, mon = 1'b0, start = 1'b0, yumi = 1'b0;
    logic [15:0] window = '0;
    logic        busy, v, ovf, busy_s, v_s, ovf_s;
    logic [15:0] cnt;
    logic [3:0]  cnt_s;

    int checks = 0, errors = 0;
    bit hist[$];
    bit static_mode = 1'b1;
    int half_lo = 2, half_hi = 2, ph_left = 1;

    typedef struct {
        int half_lo; int half_hi; int w; int hold;
        int lo; int hi; int ovf; int lo_s; int hi_s; int ovf_s;
    } vec_t;
    vec_t vecs[6];

    always #5 clk = ~clk;

    bsg_clk_gen_monitor_counter #(.window_width_p(16), .count_width_p(16), .sync_stages_p(2)) dut (
        .clk_i(clk), .reset_i(reset), .clk_monitor_i(mon), .start_i(start), .window_i(window),
        .busy_o(busy), .v_o(v), .count_o(cnt), .overflow_o(ovf), .yumi_i(yumi));

    bsg_clk_gen_monitor_counter #(.window_width_p(16), .count_width_p(4), .sync_stages_p(3)) dut_s (
        .clk_i(clk), .reset_i(reset), .clk_monitor_i(mon), .start_i(start), .window_i(window),
        .busy_o(busy_s), .v_o(v_s), .count_o(cnt_s), .overflow_o(ovf_s), .yumi_i(yumi));

    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, exp);
        end
    endtask

    task automatic chk_rng(input string name, input int got, input int lo, input int hi);
        checks++;
        if (got < lo || got > hi) begin
            errors++;
            $display("FAIL %s got %0d expected %0d..%0d", name, got, lo, hi);
        end
    endtask

    // one reference edge; history records what the synchronizer sees (0 while in reset)
    task automatic step();
        if (static_mode) mon = 1'b0;
        else if (ph_left <= 1) begin
            mon = ~mon;
            ph_left = $urandom_range(half_hi, half_lo);
        end else ph_left--;
        hist.push_back(reset ? 1'b0 : mon);
        @(posedge clk);
        #1;
    endtask

    task automatic set_mon(input int lo, input int hi);
        static_mode = (lo == 0);
        half_lo = lo;
        half_hi = hi;
        ph_left = (lo == 0) ? 1 : $urandom_range(hi, 1);
        repeat (6) step();
    endtask

    // rising edges of the delayed input seen during the W cycles after accept edge a
    function automatic void model(input int a, input int w, input int s, input int width,
                                  output int c, output int o);
        int n = 0;
        int mx = (1 << width) - 1;
        for (int j = 1; j <= w; j++)
            if (hist[a + j - s] && !hist[a + j - s - 1]) n++;
        o = (n > mx) ? 1 : 0;
        c = o ? mx : n;
    endfunction

    task automatic measure(input int w, input int hold, output int c16, output int o16,
                           output int c4, output int o4);
        int a;
        bit early;
        start = 1'b1;
        window = 16'(w);
        step();
        start = 1'b0;
        a = hist.size() - 1;
        chk("accept_busy", {busy, busy_s, v, v_s}, 4'b1100);
        chk("accept_clear", {cnt, ovf, cnt_s, ovf_s}, 0);
        early = 1'b0;
        repeat (w - 1) begin
            step();
            if (v || v_s || !busy) early = 1'b1;
        end
        chk("no_early_valid", early, 0);
        step();
        chk("valid_at_w", {v, v_s, busy, busy_s}, 4'b1111);
        model(a, w, 2, 16, c16, o16);
        model(a, w, 3, 4, c4, o4);
        chk("count", cnt, c16);
        chk("overflow", ovf, o16);
        chk("count_s", cnt_s, c4);
        chk("overflow_s", ovf_s, o4);
        for (int i = 0; i < hold; i++) begin
            start = i[0];
            window = 16'd5;
            step();
            chk("done_hold", {v, busy, cnt, ovf, cnt_s, ovf_s}, {2'b11, 16'(c16), o16[0], 4'(c4), o4[0]});
        end
        start = 1'b0;
        yumi = 1'b1;
        step();
        yumi = 1'b0;
        chk("after_yumi", {v, busy, v_s, busy_s}, 0);
        chk("idle_keeps", {cnt, ovf, cnt_s, ovf_s}, {16'(c16), o16[0], 4'(c4), o4[0]});
    endtask

    initial begin
        int c16, o16, c4, o4, a;
        bit seen_v;
        vecs[0] = '{0, 0, 50, 0, 0, 0, 0, 0, 0, 0};
        vecs[1] = '{4, 4, 800, 2, 99, 101, 0, 15, 15, 1};
        vecs[2] = '{4, 4, 1, 0, 0, 1, 0, 0, 1, 0};
        vecs[3] = '{2, 2, 200, 1, 49, 51, 0, 15, 15, 1};
        vecs[4] = '{0, 0, 30, 0, 0, 0, 0, 0, 0, 0};
        vecs[5] = '{3, 3, 61, 20, 9, 12, 0, 9, 12, 0};

        // reset held while the monitor toggles
        static_mode = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step();
            chk("reset_outputs", {busy, v, cnt, ovf, busy_s, v_s, cnt_s, ovf_s}, 0);
        end
        reset = 1'b0;
        step();
        chk("post_reset", {busy, v, cnt, ovf, busy_s, v_s, cnt_s, ovf_s}, 0);

        foreach (vecs[k]) begin
            set_mon(vecs[k].half_lo, vecs[k].half_hi);
            measure(vecs[k].w, vecs[k].hold, c16, o16, c4, o4);
            chk_rng("tbl_count", c16, vecs[k].lo, vecs[k].hi);
            chk("tbl_ovf", o16, vecs[k].ovf);
            chk_rng("tbl_count_s", c4, vecs[k].lo_s, vecs[k].hi_s);
            chk("tbl_ovf_s", o4, vecs[k].ovf_s);
        end

        // start coinciding with yumi is dropped; a start one cycle later is taken
        set_mon(3, 5);
        start = 1'b1;
        window = 16'd10;
        step();
        start = 1'b0;
        repeat (10) step();
        chk("done_reached", v, 1);
        yumi = 1'b1;
        start = 1'b1;
        step();
        yumi = 1'b0;
        start = 1'b0;
        chk("start_with_yumi", {busy, v}, 0);
        measure(12, 1, c16, o16, c4, o4);

        // reset in MEASURE cycle 30 of a 100-cycle window
        start = 1'b1;
        window = 16'd100;
        step();
        start = 1'b0;
        repeat (29) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        chk("mid_reset", {busy, v, cnt, ovf, busy_s, v_s, cnt_s, ovf_s}, 0);
        seen_v = 1'b0;
        repeat (100) begin
            step();
            if (v || busy) seen_v = 1'b1;
        end
        chk("no_result_after_reset", seen_v, 0);
        start = 1'b1;
        window = 16'd0;
        step();
        start = 1'b0;
        chk("zero_window_ignored", {busy, busy_s}, 0);

        for (int r = 0; r < 12; r++) begin
            a = $urandom_range(5, 2);
            set_mon(a, a + $urandom_range(4, 0));
            measure($urandom_range(400, 1), $urandom_range(3, 0), c16, o16, c4, o4);
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
